// File: rtl/duty_ramp.sv
// duty_ramp: breathing-sequence generator for a downstream PWM.
// A prescaler produces step strobes, a divider turns them into level updates,
// and a five-state FSM ramps the level up, holds, ramps down, holds, repeats.
// Optional build macro: DUTY_RAMP_GAMMA_EN selects a square-law duty mapping.
module duty_ramp #(
    parameter int N = 8,
    parameter int P = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic         stop,
    input  logic [P-1:0] rate,
    input  logic [7:0]   ramp_div,
    input  logic [7:0]   hold_ticks,
    output logic         step,
    output logic [N-1:0] duty,
    output logic         busy,
    output logic         cycle_done
);

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO
    } state_t;

    localparam logic [N-1:0] LVL_MAX = '1;
    localparam logic [N-1:0] LVL_ONE = N'(1);
    localparam logic [P-1:0] PRE_ONE = P'(1);

    state_t       state, state_nxt;
    logic [N-1:0] level, level_nxt;
    logic [7:0]   hold_cnt, hold_nxt;
    logic         stop_req, stop_nxt;
    logic [P-1:0] presc, presc_nxt;
    logic [7:0]   div, div_nxt;
    logic         active;
    logic         update;

    // Registered state; synchronous reset aborts any sequence at once
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            level    <= '0;
            hold_cnt <= '0;
            stop_req <= 1'b0;
            presc    <= '0;
            div      <= '0;
        end else begin
            state    <= state_nxt;
            level    <= level_nxt;
            hold_cnt <= hold_nxt;
            stop_req <= stop_nxt;
            presc    <= presc_nxt;
            div      <= div_nxt;
        end
    end

    // Timebase, update divider and ramp FSM next-state/strobe decode
    always_comb begin
        state_nxt  = state;
        level_nxt  = level;
        hold_nxt   = hold_cnt;
        stop_nxt   = stop_req;
        presc_nxt  = presc;
        div_nxt    = div;
        step       = 1'b0;
        update     = 1'b0;
        cycle_done = 1'b0;
        // rst gates the strobes so nothing leaks out while reset is held
        active     = ena && !rst;

        if (active) begin
            step      = (presc == rate);
            presc_nxt = step ? '0 : presc + PRE_ONE;
            if (step) begin
                div_nxt = (div == ramp_div) ? '0 : div + 8'd1;
            end
            update = step && (div == ramp_div);

            if (state != IDLE && stop) begin
                stop_nxt = 1'b1;
            end

            case (state)
                IDLE: begin
                    level_nxt = '0;
                    if (start) begin
                        state_nxt = UP;
                        presc_nxt = '0;
                        div_nxt   = '0;
                        stop_nxt  = stop;
                    end
                end
                UP: begin
                    if (update) begin
                        level_nxt = level + LVL_ONE;
                        if (level_nxt == LVL_MAX) begin
                            state_nxt = HOLD_HI;
                            hold_nxt  = '0;
                        end
                    end
                end
                HOLD_HI: begin
                    if (update) begin
                        if (hold_cnt == hold_ticks) begin
                            state_nxt = DOWN;
                            level_nxt = level - LVL_ONE;
                        end else begin
                            hold_nxt = hold_cnt + 8'd1;
                        end
                    end
                end
                DOWN: begin
                    if (update) begin
                        level_nxt = level - LVL_ONE;
                        if (level_nxt == '0) begin
                            state_nxt = HOLD_LO;
                            hold_nxt  = '0;
                        end
                    end
                end
                HOLD_LO: begin
                    if (update) begin
                        if (hold_cnt == hold_ticks) begin
                            cycle_done = 1'b1;
                            if (stop_req) begin
                                state_nxt = IDLE;
                                stop_nxt  = 1'b0;
                            end else begin
                                state_nxt = UP;
                                level_nxt = LVL_ONE;
                            end
                        end else begin
                            hold_nxt = hold_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    level_nxt = '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef DUTY_RAMP_GAMMA_EN
    logic [2*N-1:0] level_sq;

    assign level_sq = {{N{1'b0}}, level} * {{N{1'b0}}, level};
    assign duty     = (level == LVL_MAX) ? LVL_MAX : level_sq[2*N-1:N];
`else
    assign duty = level;
`endif

endmodule

// File: tb/tb_duty_ramp.sv
// tb_duty_ramp: scoreboard bench for duty_ramp (N=4, P=8).
// Each scenario queues per-cycle stimulus with the expected outputs, then
// replays the queue, driving at negedge and comparing 1ns later.
module tb_duty_ramp;

    logic       clk = 1'b0;
    logic       rst, ena, start, stop;
    logic [7:0] rate, ramp_div, hold_ticks;
    logic       step, busy, cycle_done;
    logic [3:0] duty;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       r, e, s, p;
        logic [7:0] rt, rd;
        logic [3:0] lvl;
        logic       stp, done, bsy;
    } vec_t;

    vec_t q[$];

    duty_ramp #(.N(4), .P(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .start      (start),
        .stop       (stop),
        .rate       (rate),
        .ramp_div   (ramp_div),
        .hold_ticks (hold_ticks),
        .step       (step),
        .duty       (duty),
        .busy       (busy),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] gam(input logic [3:0] l);
`ifdef DUTY_RAMP_GAMMA_EN
        logic [7:0] sq;
        sq = {4'b0, l} * {4'b0, l};
        return (l == 4'hF) ? 4'hF : sq[7:4];
`else
        return l;
`endif
    endfunction

    function automatic void push(input logic r, input logic e, input logic s, input logic p,
                                 input logic [7:0] rt, input logic [7:0] rd, input int lvl,
                                 input logic stp, input logic done, input logic bsy);
        vec_t v;
        v.r = r; v.e = e; v.s = s; v.p = p; v.rt = rt; v.rd = rd;
        v.lvl = 4'(lvl); v.stp = stp; v.done = done; v.bsy = bsy;
        q.push_back(v);
    endfunction

    task automatic test_reset();
        vec_t v;
        int k = 0;
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            @(negedge clk);
            rst = v.r; ena = v.e; start = v.s; stop = v.p; rate = v.rt; ramp_div = v.rd;
            #1;
            n_cmp++;
            if (duty !== gam(v.lvl) || step !== v.stp || busy !== v.bsy || cycle_done !== v.done) begin
                n_err++;
                $display("FAIL reset cyc=%0d duty=%0d exp=%0d step=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                         k, duty, gam(v.lvl), step, v.stp, busy, v.bsy, cycle_done, v.done);
            end
            k++;
        end
    endtask

    task automatic test_prescaler();
        vec_t v;
        int k = 0;
        for (int i = 0; i < 12; i++) push(0, 1, 0, 0, 2, 0, 0, (i % 3 == 2), 0, 0);
        for (int i = 0; i < 5; i++) push(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            @(negedge clk);
            rst = v.r; ena = v.e; start = v.s; stop = v.p; rate = v.rt; ramp_div = v.rd;
            #1;
            n_cmp++;
            if (duty !== gam(v.lvl) || step !== v.stp || busy !== v.bsy || cycle_done !== v.done) begin
                n_err++;
                $display("FAIL prescaler cyc=%0d duty=%0d exp=%0d step=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                         k, duty, gam(v.lvl), step, v.stp, busy, v.bsy, cycle_done, v.done);
            end
            k++;
        end
    endtask

    task automatic test_triangle();
        vec_t v;
        int k = 0;
        push(0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i <= 15; i++) push(0, 1, 0, 0, 0, 0, i, 1, 0, 1);
        push(0, 1, 0, 0, 0, 0, 15, 1, 0, 1);
        for (int i = 14; i >= 1; i--) push(0, 1, 0, 0, 0, 0, i, 1, 0, 1);
        push(0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        push(0, 1, 0, 0, 0, 0, 0, 1, 1, 1);
        push(0, 1, 0, 0, 0, 0, 1, 1, 0, 1);
        while (q.size() > 0) begin
            v = q.pop_front();
            @(negedge clk);
            rst = v.r; ena = v.e; start = v.s; stop = v.p; rate = v.rt; ramp_div = v.rd;
            #1;
            n_cmp++;
            if (duty !== gam(v.lvl) || step !== v.stp || busy !== v.bsy || cycle_done !== v.done) begin
                n_err++;
                $display("FAIL triangle cyc=%0d duty=%0d exp=%0d step=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                         k, duty, gam(v.lvl), step, v.stp, busy, v.bsy, cycle_done, v.done);
            end
            k++;
        end
    endtask

    task automatic test_graceful_stop();
        vec_t v;
        int k = 0;
        for (int i = 2; i <= 8; i++) push(0, 1, 0, 0, 0, 0, i, 1, 0, 1);
        push(0, 1, 0, 1, 0, 0, 9, 1, 0, 1);
        for (int i = 10; i <= 15; i++) push(0, 1, 0, 0, 0, 0, i, 1, 0, 1);
        push(0, 1, 0, 0, 0, 0, 15, 1, 0, 1);
        for (int i = 14; i >= 1; i--) push(0, 1, 0, 0, 0, 0, i, 1, 0, 1);
        push(0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        push(0, 1, 0, 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) push(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            @(negedge clk);
            rst = v.r; ena = v.e; start = v.s; stop = v.p; rate = v.rt; ramp_div = v.rd;
            #1;
            n_cmp++;
            if (duty !== gam(v.lvl) || step !== v.stp || busy !== v.bsy || cycle_done !== v.done) begin
                n_err++;
                $display("FAIL graceful_stop cyc=%0d duty=%0d exp=%0d step=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                         k, duty, gam(v.lvl), step, v.stp, busy, v.bsy, cycle_done, v.done);
            end
            k++;
        end
    endtask

    task automatic test_divider();
        vec_t v;
        int k = 0;
        int lv;
        push(0, 1, 1, 0, 1, 2, 0, 0, 0, 0);
        for (int d = 1; d <= 14; d++) begin
            lv = (d < 7) ? 0 : ((d < 13) ? 1 : 2);
            push(0, 1, 0, 0, 1, 2, lv, (d >= 2 && d % 2 == 0), 0, 1);
        end
        push(1, 1, 0, 0, 1, 2, 2, 0, 0, 1);
        push(0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            @(negedge clk);
            rst = v.r; ena = v.e; start = v.s; stop = v.p; rate = v.rt; ramp_div = v.rd;
            #1;
            n_cmp++;
            if (duty !== gam(v.lvl) || step !== v.stp || busy !== v.bsy || cycle_done !== v.done) begin
                n_err++;
                $display("FAIL divider cyc=%0d duty=%0d exp=%0d step=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                         k, duty, gam(v.lvl), step, v.stp, busy, v.bsy, cycle_done, v.done);
            end
            k++;
        end
    endtask

    task automatic test_freeze_reset();
        vec_t v;
        int k = 0;
        push(0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        push(0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 1; i <= 4; i++) push(0, 1, 0, 0, 0, 0, i, 1, 0, 1);
        for (int i = 0; i < 10; i++) push(0, 0, 0, 0, 0, 0, 5, 0, 0, 1);
        push(0, 1, 1, 0, 0, 0, 5, 1, 0, 1);
        for (int i = 6; i <= 11; i++) push(0, 1, 0, 0, 0, 0, i, 1, 0, 1);
        push(1, 1, 0, 0, 0, 0, 12, 0, 0, 1);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            @(negedge clk);
            rst = v.r; ena = v.e; start = v.s; stop = v.p; rate = v.rt; ramp_div = v.rd;
            #1;
            n_cmp++;
            if (duty !== gam(v.lvl) || step !== v.stp || busy !== v.bsy || cycle_done !== v.done) begin
                n_err++;
                $display("FAIL freeze_reset cyc=%0d duty=%0d exp=%0d step=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                         k, duty, gam(v.lvl), step, v.stp, busy, v.bsy, cycle_done, v.done);
            end
            k++;
        end
    endtask

    task automatic test_start_stop_same_cycle();
        vec_t v;
        int k = 0;
        hold_ticks = 8'd0;
        push(0, 1, 1, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i <= 15; i++) push(0, 1, 0, 0, 0, 0, i, 1, 0, 1);
        for (int i = 14; i >= 1; i--) push(0, 1, 0, 0, 0, 0, i, 1, 0, 1);
        push(0, 1, 0, 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) push(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        while (q.size() > 0) begin
            v = q.pop_front();
            @(negedge clk);
            rst = v.r; ena = v.e; start = v.s; stop = v.p; rate = v.rt; ramp_div = v.rd;
            #1;
            n_cmp++;
            if (duty !== gam(v.lvl) || step !== v.stp || busy !== v.bsy || cycle_done !== v.done) begin
                n_err++;
                $display("FAIL start_stop cyc=%0d duty=%0d exp=%0d step=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                         k, duty, gam(v.lvl), step, v.stp, busy, v.bsy, cycle_done, v.done);
            end
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        ena        = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        rate       = 8'd0;
        ramp_div   = 8'd0;
        hold_ticks = 8'd1;
        repeat (3) @(posedge clk);
        test_reset();
        test_prescaler();
        test_triangle();
        test_graceful_stop();
        test_divider();
        test_freeze_reset();
        test_start_stop_same_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
